// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel state encoding and prescaler sizing.
package timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Prescaler counts 0..tick_cyc-1; keep at least one bit so TICK_CYC==1 still elaborates.
  function automatic int pre_width(input int tick_cyc);
    int w;
    w = $clog2(tick_cyc);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle between the game FSM (master) and the timer bank (slave).
interface timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 16
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       pause;
  logic [NUM_CH-1:0]       reload_mode;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       halfway;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH*DUR_W-1:0] remaining;

  modport master (
    output start, cancel, pause, reload_mode, duration,
    input  done, halfway, running, remaining
  );

  modport slave (
    input  start, cancel, pause, reload_mode, duration,
    output done, halfway, running, remaining
  );
endinterface

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN FSM, tick prescaler, remaining count, latched period and mode.
module timer_channel
  import timer_pkg::*;
#(
  parameter int TICK_CYC = 4,
  parameter int DUR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_cancel,
  input  logic             i_pause,
  input  logic             i_reload_mode,
  input  logic [DUR_W-1:0] i_duration,
  output logic             o_done,
  output logic             o_halfway,
  output logic             o_running,
  output logic [DUR_W-1:0] o_remaining
);
  localparam int              PW       = pre_width(TICK_CYC);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_CYC - 1);

  state_t             r_state, w_state_next;
  logic [PW-1:0]      r_pre, w_pre_next;
  logic [DUR_W-1:0]   r_rem, w_rem_next;
  logic [DUR_W-1:0]   r_period, w_period_next;
  logic               r_mode, w_mode_next;
  logic               r_done, w_done_next;
  logic               r_half, w_half_next;
  logic [DUR_W-1:0]   w_rem_dec;
  logic [DUR_W-1:0]   w_half_pt;

  assign w_rem_dec = r_rem - DUR_W'(1);
  assign w_half_pt = r_period >> 1;

  always_comb begin
    w_state_next  = r_state;
    w_pre_next    = r_pre;
    w_rem_next    = r_rem;
    w_period_next = r_period;
    w_mode_next   = r_mode;
    w_done_next   = 1'b0;
    w_half_next   = 1'b0;
    if (i_cancel) begin
      w_state_next = ST_IDLE;
      w_pre_next   = '0;
      w_rem_next   = '0;
    end else if (i_start) begin
      w_period_next = i_duration;
      w_mode_next   = i_reload_mode;
      w_pre_next    = '0;
      w_rem_next    = i_duration;
      // A zero-length timer expires immediately without ever reporting running.
      if (i_duration == '0) begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end else begin
        w_state_next = ST_RUN;
      end
    end else if (r_state == ST_RUN && !i_pause) begin
      if (r_pre == PRE_LAST) begin
        w_pre_next = '0;
        w_rem_next = w_rem_dec;
        if (w_half_pt != '0 && w_rem_dec == w_half_pt)
          w_half_next = 1'b1;
        if (r_rem == DUR_W'(1)) begin
          w_done_next = 1'b1;
          if (r_mode)
            w_rem_next = r_period;
          else
            w_state_next = ST_IDLE;
        end
      end else begin
        w_pre_next = r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pre    <= '0;
      r_rem    <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
      r_half   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pre    <= w_pre_next;
      r_rem    <= w_rem_next;
      r_period <= w_period_next;
      r_mode   <= w_mode_next;
      r_done   <= w_done_next;
      r_half   <= w_half_next;
    end
  end

  assign o_done      = r_done;
  assign o_halfway   = r_half;
  assign o_running   = (r_state == ST_RUN);
  assign o_remaining = r_rem;
endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent countdown timers sharing one clock and tick rate.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int DUR_W      = 16
) (
  input logic         clk,
  input logic         reset,
  timer_bank_if.slave bus
);
  localparam int TICK_CYC = CLOCK_FREQ / TICK_HZ;

  generate
    if (TICK_CYC < 1) begin : g_bad_tick
      $error("timer_bank: CLOCK_FREQ/TICK_HZ must be at least 1");
    end
  endgenerate

  logic [NUM_CH-1:0]       w_done;
  logic [NUM_CH-1:0]       w_halfway;
  logic [NUM_CH-1:0]       w_running;
  logic [NUM_CH*DUR_W-1:0] w_remaining;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_channel #(
        .TICK_CYC (TICK_CYC),
        .DUR_W    (DUR_W)
      ) u_ch (
        .clk           (clk),
        .reset         (reset),
        .i_start       (bus.start[gi]),
        .i_cancel      (bus.cancel[gi]),
        .i_pause       (bus.pause[gi]),
        .i_reload_mode (bus.reload_mode[gi]),
        .i_duration    (bus.duration[gi*DUR_W +: DUR_W]),
        .o_done        (w_done[gi]),
        .o_halfway     (w_halfway[gi]),
        .o_running     (w_running[gi]),
        .o_remaining   (w_remaining[gi*DUR_W +: DUR_W])
      );
    end
  endgenerate

  assign bus.done      = w_done;
  assign bus.halfway   = w_halfway;
  assign bus.running   = w_running;
  assign bus.remaining = w_remaining;
endmodule

// File: tb/tb_timer_bank.sv
// Random and directed stimulus for timer_bank, checked every cycle against a cycle-count reference model.
module tb_timer_bank;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int CF = 40;
  localparam int TH = 10;
  localparam int TC = CF / TH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_bank_if #(.NUM_CH(NC), .DUR_W(DW)) bus ();

  timer_bank #(
    .NUM_CH(NC), .CLOCK_FREQ(CF), .TICK_HZ(TH), .DUR_W(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: count un-paused running cycles since start/reload and derive everything from that.
  bit m_run  [NC];
  int m_per  [NC];
  bit m_mode [NC];
  int m_cnt  [NC];
  int m_rem  [NC];
  bit m_done [NC];
  bit m_half [NC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NC; i++) begin
      m_done[i] = 1'b0;
      m_half[i] = 1'b0;
      if (reset) begin
        m_run[i] = 0; m_per[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_rem[i] = 0;
      end else if (bus.cancel[i]) begin
        m_run[i] = 0; m_rem[i] = 0;
      end else if (bus.start[i]) begin
        m_per[i]  = int'(bus.duration[i*DW +: DW]);
        m_mode[i] = bus.reload_mode[i];
        m_cnt[i]  = 0;
        m_rem[i]  = m_per[i];
        if (m_per[i] == 0) begin
          m_run[i] = 0; m_done[i] = 1'b1;
        end else begin
          m_run[i] = 1;
        end
      end else if (m_run[i] && !bus.pause[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] % TC == 0) begin
          m_rem[i] = m_per[i] - m_cnt[i] / TC;
          if (m_per[i] / 2 > 0 && m_rem[i] == m_per[i] / 2) m_half[i] = 1'b1;
          if (m_rem[i] == 0) begin
            m_done[i] = 1'b1;
            if (m_mode[i]) begin
              m_cnt[i] = 0; m_rem[i] = m_per[i];
            end else begin
              m_run[i] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic do_edge(input string phase);
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("%s_done%0d", phase, i), 64'(bus.done[i]), 64'(m_done[i]));
      chk($sformatf("%s_half%0d", phase, i), 64'(bus.halfway[i]), 64'(m_half[i]));
      chk($sformatf("%s_run%0d", phase, i), 64'(bus.running[i]), 64'(m_run[i]));
      chk($sformatf("%s_rem%0d", phase, i), 64'(bus.remaining[i*DW +: DW]), 64'(m_rem[i]));
    end
  endtask

  task automatic set_dur(input int ch, input int d);
    bus.duration[ch*DW +: DW] = DW'(d);
  endtask

  int fd [NC];
  int fh [NC];
  int nd1;

  initial begin
    reset = 1'b1;
    bus.start = '0; bus.cancel = '0; bus.pause = '0; bus.reload_mode = '0; bus.duration = '0;
    do_edge("reset");
    do_edge("reset");
    chk("reset_all_out", 64'({bus.done, bus.halfway, bus.running}), 64'(0));
    reset = 1'b0;

    // Directed: ch0 one-shot 5, ch1 reload 3, ch2 one-shot 4 paused edges 5..14, ch3 one-shot 1.
    for (int i = 0; i < NC; i++) begin fd[i] = -1; fh[i] = -1; end
    nd1 = 0;
    set_dur(0, 5); set_dur(1, 3); set_dur(2, 4); set_dur(3, 1);
    bus.reload_mode = 4'b0010;
    for (int e = 0; e <= 40; e++) begin
      bus.start    = (e == 0) ? 4'hF : 4'h0;
      bus.pause[2] = (e >= 5 && e <= 14);
      do_edge("dir");
      for (int i = 0; i < NC; i++) begin
        if (bus.done[i] && fd[i] < 0) fd[i] = e;
        if (bus.halfway[i] && fh[i] < 0) fh[i] = e;
      end
      nd1 += int'(bus.done[1]);
    end
    bus.pause = '0;
    $display("directed: first done %0d %0d %0d %0d", fd[0], fd[1], fd[2], fd[3]);
    chk("oneshot5_done_edge", 64'(fd[0]), 64'(20));
    chk("oneshot5_half_edge", 64'(fh[0]), 64'(12));
    chk("reload3_done_edge", 64'(fd[1]), 64'(12));
    chk("reload3_half_edge", 64'(fh[1]), 64'(8));
    chk("reload3_done_count", 64'(nd1), 64'(3));
    chk("pause4_done_edge", 64'(fd[2]), 64'(26));
    chk("d1_done_edge", 64'(fd[3]), 64'(4));
    chk("d1_no_half", 64'(fh[3]), 64'(-1));

    // Reset mid-run at edge 10, then a fresh one-shot start.
    bus.reload_mode = '0;
    for (int i = 0; i < NC; i++) set_dur(i, 5);
    for (int e = 0; e <= 12; e++) begin
      bus.start = (e == 0) ? 4'hF : 4'h0;
      reset     = (e == 10);
      do_edge("midreset");
    end
    reset = 1'b0;
    $display("mid-run reset applied");

    // Randomized traffic over all channels.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NC; i++) begin
        bus.start[i]       = ($urandom % 16 == 0);
        bus.cancel[i]      = ($urandom % 40 == 0);
        bus.reload_mode[i] = $urandom % 2;
        if ($urandom % 12 == 0) bus.pause[i] = ~bus.pause[i];
        set_dur(i, $urandom_range(0, 9));
      end
      reset = ($urandom % 700 == 0);
      do_edge("rand");
    end
    reset = 1'b0;
    $display("random phase complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
